// File: rtl/execute_stage_if.sv
// EX/MEM pipeline bus between the execute stage (master) and the memory stage (slave).
interface execute_stage_if #(
    parameter int DW = 32,
    parameter int RW = 5
);
    logic          valid_out;
    logic [DW-1:0] alu_result;
    logic [DW-1:0] write_data_out;
    logic          zero_out;
    logic [DW-1:0] branch_target;
    logic          mem_write_out;
    logic          branch_out;
    logic          reg_write_out;
    logic          mem_to_reg_out;
    logic [RW-1:0] write_reg_out;

    modport master (
        output valid_out, alu_result, write_data_out, zero_out, branch_target,
               mem_write_out, branch_out, reg_write_out, mem_to_reg_out, write_reg_out
    );

    modport slave (
        input valid_out, alu_result, write_data_out, zero_out, branch_target,
              mem_write_out, branch_out, reg_write_out, mem_to_reg_out, write_reg_out
    );
endinterface

// File: rtl/execute_stage.sv
// EX stage: single-cycle ALU, branch target, and a DW-cycle iterative signed MULT/DIV
// unit owning HI/LO; all results are registered into the EX/MEM bus.
//
// state | meaning
// IDLE  | ALU instructions flow through; MULT/DIV may be accepted
// BUSY  | one multiply/divide step per cycle, upstream stalled, EX/MEM gets bubbles
module execute_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid_in,
    input  logic [3:0]    alu_op,
    input  logic [DW-1:0] read_data_1,
    input  logic [DW-1:0] read_data_2,
    input  logic [DW-1:0] imm_ext,
    input  logic          alu_src,
    input  logic [4:0]    shamt,
    input  logic [DW-1:0] pc_plus4,
    input  logic          mem_write_in,
    input  logic          branch_in,
    input  logic          reg_write_in,
    input  logic          mem_to_reg_in,
    input  logic [RW-1:0] write_reg_in,
    input  logic          flush,
    output logic          stall,
    execute_stage_if.master ex_mem
);
    localparam int CW = $clog2(DW) + 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic [DW-1:0] hi, lo;
    logic [DW-1:0] work_hi, work_lo, b_mag;
    logic          op_div, neg_res, sign_a, div_zero;

    logic [DW-1:0] op_b, alu_val, a_mag_in, b_mag_in;
    logic          is_muldiv, issue, accept;

    logic [DW:0]     mul_sum, div_shift;
    logic [DW+1:0]   div_diff;
    logic            div_ok;
    logic [DW-1:0]   step_hi, step_lo, quot, rem;
    logic [2*DW-1:0] prod_mag, prod_signed;

    assign stall     = (state == BUSY);
    assign op_b      = alu_src ? imm_ext : read_data_2;
    assign is_muldiv = (alu_op == 4'hC) || (alu_op == 4'hD);
    assign issue     = (state == IDLE) && valid_in && !flush;
    assign accept    = issue && is_muldiv;
    assign a_mag_in  = read_data_1[DW-1] ? -read_data_1 : read_data_1;
    assign b_mag_in  = op_b[DW-1] ? -op_b : op_b;

    always_comb begin
        alu_val = '0;
        case (alu_op)
            4'h0: alu_val = read_data_1 + op_b;
            4'h1: alu_val = read_data_1 - op_b;
            4'h2: alu_val = read_data_1 & op_b;
            4'h3: alu_val = read_data_1 | op_b;
            4'h4: alu_val = read_data_1 ^ op_b;
            4'h5: alu_val = ~(read_data_1 | op_b);
            4'h6: alu_val = {{(DW-1){1'b0}}, $signed(read_data_1) < $signed(op_b)};
            4'h7: alu_val = {{(DW-1){1'b0}}, read_data_1 < op_b};
            4'h8: alu_val = op_b << shamt;
            4'h9: alu_val = op_b >> shamt;
            4'hA: alu_val = $signed(op_b) >>> shamt;
            4'hB: alu_val = {{(DW-16){1'b0}}, imm_ext[15:0]} << 16;
            4'hE: alu_val = hi;
            4'hF: alu_val = lo;
            default: alu_val = '0;
        endcase
    end

    // Multiply: shift-add with the multiplier in work_lo; divide: restoring with
    // the remainder in work_hi and quotient bits shifted into work_lo.
    always_comb begin
        mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, b_mag} : '0);
        div_shift = {work_hi, work_lo[DW-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, b_mag};
        div_ok    = ~div_diff[DW+1];
        if (op_div) begin
            step_hi = div_ok ? div_diff[DW-1:0] : div_shift[DW-1:0];
            step_lo = {work_lo[DW-2:0], div_ok};
        end else begin
            step_hi = mul_sum[DW:1];
            step_lo = {mul_sum[0], work_lo[DW-1:1]};
        end
        prod_mag    = {step_hi, step_lo};
        prod_signed = neg_res ? -prod_mag : prod_mag;
        quot        = div_zero ? '1 : (neg_res ? -step_lo : step_lo);
        rem         = sign_a ? -step_hi : step_hi;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                 <= IDLE;
            count                 <= '0;
            hi                    <= '0;
            lo                    <= '0;
            work_hi               <= '0;
            work_lo               <= '0;
            b_mag                 <= '0;
            op_div                <= 1'b0;
            neg_res               <= 1'b0;
            sign_a                <= 1'b0;
            div_zero              <= 1'b0;
            ex_mem.valid_out      <= 1'b0;
            ex_mem.alu_result     <= '0;
            ex_mem.write_data_out <= '0;
            ex_mem.zero_out       <= 1'b0;
            ex_mem.branch_target  <= '0;
            ex_mem.mem_write_out  <= 1'b0;
            ex_mem.branch_out     <= 1'b0;
            ex_mem.reg_write_out  <= 1'b0;
            ex_mem.mem_to_reg_out <= 1'b0;
            ex_mem.write_reg_out  <= '0;
        end else begin
            ex_mem.alu_result     <= alu_val;
            ex_mem.write_data_out <= read_data_2;
            ex_mem.zero_out       <= (alu_val == '0);
            ex_mem.branch_target  <= pc_plus4 + (imm_ext << 2);

            if (issue) begin
                ex_mem.valid_out      <= 1'b1;
                ex_mem.mem_write_out  <= mem_write_in  && !is_muldiv;
                ex_mem.branch_out     <= branch_in     && !is_muldiv;
                ex_mem.reg_write_out  <= reg_write_in  && !is_muldiv;
                ex_mem.mem_to_reg_out <= mem_to_reg_in && !is_muldiv;
                ex_mem.write_reg_out  <= write_reg_in;
            end else begin
                ex_mem.valid_out      <= 1'b0;
                ex_mem.mem_write_out  <= 1'b0;
                ex_mem.branch_out     <= 1'b0;
                ex_mem.reg_write_out  <= 1'b0;
                ex_mem.mem_to_reg_out <= 1'b0;
                ex_mem.write_reg_out  <= '0;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        state    <= BUSY;
                        count    <= CW'(DW);
                        work_hi  <= '0;
                        work_lo  <= a_mag_in;
                        b_mag    <= b_mag_in;
                        op_div   <= alu_op[0];
                        neg_res  <= read_data_1[DW-1] ^ op_b[DW-1];
                        sign_a   <= read_data_1[DW-1];
                        div_zero <= (op_b == '0);
                    end
                end
                BUSY: begin
                    work_hi <= step_hi;
                    work_lo <= step_lo;
                    count   <= count - CW'(1);
                    if (count == CW'(1)) begin
                        state <= IDLE;
                        if (op_div) begin
                            hi <= rem;
                            lo <= quot;
                        end else begin
                            {hi, lo} <= prod_signed;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
